// File: rtl/cep_scratchpad_bd_pkg.sv
// Shared types and constants for the scratchpad backdoor responder.
// Contents: FSM state enum bd_state_t, data/mask widths and the byte-offset
// width that separates a byte address from a 64-bit word address.
package cep_scratchpad_bd_pkg;

  localparam int BD_DATA_W   = 64;
  localparam int BD_MASK_W   = 8;
  localparam int BD_BYTE_OFS = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    READ_WAIT,
    RESP
  } bd_state_t;

endpackage

// File: rtl/scratchpad_backdoor_responder.sv
// Purpose: shares the scratchpad memory port between the system requester and a
//   64-bit backdoor read/write command channel; one backdoor op in flight.
// Latency: accept at T -> write rsp T+2, read rsp T+3, address error rsp T+1
//   (plus up to SYS_STARVE_LIMIT cycles while the system holds the port).
// Backpressure: bd_req_ready only in IDLE; a response is held until bd_rsp_ready,
//   and the memory port reverts to the system while it waits.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bd_req_* / bd_rsp_*       backdoor request and response valid/ready channels
//   sys_*                     system requester (granted combinationally via sys_gnt_o)
//   sp_*                      scratchpad memory port (1-cycle registered read data)
module scratchpad_backdoor_responder
  import cep_scratchpad_bd_pkg::*;
#(
  parameter int SP_ADDR_WIDTH    = 13,
  parameter int SYS_STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     bd_req_valid,
  output logic                     bd_req_ready,
  input  logic                     bd_req_write,
  input  logic [31:0]              bd_req_addr,
  input  logic [BD_DATA_W-1:0]     bd_req_wdata,
  input  logic [BD_MASK_W-1:0]     bd_req_mask,

  output logic                     bd_rsp_valid,
  input  logic                     bd_rsp_ready,
  output logic [BD_DATA_W-1:0]     bd_rsp_rdata,
  output logic                     bd_rsp_err,

  input  logic                     sys_req_i,
  input  logic                     sys_write_i,
  input  logic [SP_ADDR_WIDTH-1:0] sys_addr_i,
  input  logic [BD_DATA_W-1:0]     sys_wdata_i,
  input  logic [BD_MASK_W-1:0]     sys_mask_i,
  output logic                     sys_gnt_o,
  output logic [BD_DATA_W-1:0]     sys_rdata_o,

  output logic                     sp_write_o,
  output logic [SP_ADDR_WIDTH-1:0] sp_addr_o,
  output logic [BD_DATA_W-1:0]     sp_wdata_o,
  output logic [BD_MASK_W-1:0]     sp_mask_o,
  input  logic [BD_DATA_W-1:0]     sp_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(SYS_STARVE_LIMIT);

  bd_state_t              state;
  logic                   lat_write;
  logic [SP_ADDR_WIDTH-1:0] lat_waddr;
  logic [BD_DATA_W-1:0]   lat_wdata;
  logic [BD_MASK_W-1:0]   lat_mask;
  logic [3:0]             starve_cnt;
  logic                   rsp_valid_q;
  logic [BD_DATA_W-1:0]   rsp_rdata_q;
  logic                   rsp_err_q;

  logic bd_accept;
  logic bd_addr_bad;
  logic bd_owns_port;

  // Ready is masked by rst so requests presented during reset are never taken.
  assign bd_req_ready = (state == IDLE) & ~rst;
  assign bd_accept    = bd_req_valid & bd_req_ready;

  // Byte address must be word aligned and lie inside the 2^(W+3)-byte window.
  assign bd_addr_bad = (bd_req_addr[BD_BYTE_OFS-1:0] != '0) |
                       ((bd_req_addr >> (SP_ADDR_WIDTH + BD_BYTE_OFS)) != 32'd0);

  // The backdoor only ever drives the port during ISSUE, and only when the
  // system is idle or has already been granted STARVE_LIM times in a row.
  // Not gated by rst: a write on the port in the rst cycle still lands.
  assign bd_owns_port = (state == ISSUE) & (~sys_req_i | (starve_cnt == STARVE_LIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bd_accept) begin
            lat_write   <= bd_req_write;
            lat_waddr   <= bd_req_addr[SP_ADDR_WIDTH+BD_BYTE_OFS-1:BD_BYTE_OFS];
            lat_wdata   <= bd_req_wdata;
            lat_mask    <= bd_req_mask;
            rsp_rdata_q <= '0;
            if (bd_addr_bad) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_err_q <= 1'b0;
              state     <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (bd_owns_port) begin
            starve_cnt <= '0;
            if (lat_write) begin
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              state <= READ_WAIT;
            end
          end else if (starve_cnt != STARVE_LIM) begin
            // Lost to the system; never exceeds the limit because reaching it
            // forces a backdoor win on the next ISSUE cycle.
            starve_cnt <= starve_cnt + 4'd1;
          end
        end

        READ_WAIT: begin
          rsp_rdata_q <= sp_rdata_i;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (bd_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bd_rsp_valid = rsp_valid_q;
  assign bd_rsp_rdata = rsp_rdata_q;
  assign bd_rsp_err   = rsp_err_q;

  // Memory port mux: system mirror by default, backdoor only on its win cycle.
  always_comb begin
    sp_write_o = sys_write_i & sys_req_i;
    sp_addr_o  = sys_addr_i;
    sp_wdata_o = sys_wdata_i;
    sp_mask_o  = sys_mask_i;
    if (bd_owns_port) begin
      sp_write_o = lat_write;
      sp_addr_o  = lat_waddr;
      sp_wdata_o = lat_wdata;
      sp_mask_o  = lat_write ? lat_mask : '0;
    end
  end

  assign sys_gnt_o   = sys_req_i & ~bd_owns_port;
  assign sys_rdata_o = sp_rdata_i;

endmodule
